// File: rtl/st7789_pkg.sv
// Shared constants and types for the ST7789 SPI receiver: command opcodes,
// decoder states and the window span payload.
package st7789_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned COLOR_W = 16;

  localparam logic [BYTE_W-1:0] CMD_CASET = 8'h2A;
  localparam logic [BYTE_W-1:0] CMD_RASET = 8'h2B;
  localparam logic [BYTE_W-1:0] CMD_RAMWR = 8'h2C;
  localparam logic [BYTE_W-1:0] CMD_NOP   = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CASET = 3'd1,
    RASET = 3'd2,
    RAMWR = 3'd3,
    SKIP  = 3'd4
  } dec_state_t;

  // Inclusive start/end of a column or row address window.
  typedef struct packed {
    logic [COORD_W-1:0] s;
    logic [COORD_W-1:0] e;
  } span_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizes the pins, detects rising
// spi_clk edges, assembles MSB-first bytes and frames them with csn.
module spi_byte_rx
  import st7789_pkg::*;
#(
  parameter int unsigned c_clk_polarity = 1,
  parameter int unsigned c_use_csn      = 0,
  parameter int unsigned c_sync_stages  = 2
) (
  input  logic              clk,
  input  logic              resn,
  input  logic              spi_csn_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_dc_i,
  input  logic              spi_resn_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              rx_dc_o,
  output logic              rx_valid_o,
  output logic              spi_resn_o
);

  localparam int unsigned SS = c_sync_stages;
  localparam logic CLK_IDLE = 1'(c_clk_polarity);

  logic [SS-1:0] csn_sync_q, clk_sync_q, mosi_sync_q, dc_sync_q, resn_sync_q;
  logic          csn_s, clk_s, mosi_s, dc_s, resn_s;
  logic          clk_prev_q;
  logic          sclk_rise;

  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              dc_cap_q, dc_cap_d;
  logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic              rx_dc_q, rx_dc_d;
  logic              rx_valid_q, rx_valid_d;

  assign csn_s  = csn_sync_q[SS-1];
  assign clk_s  = clk_sync_q[SS-1];
  assign mosi_s = mosi_sync_q[SS-1];
  assign dc_s   = dc_sync_q[SS-1];
  assign resn_s = resn_sync_q[SS-1];

  assign sclk_rise = clk_s & ~clk_prev_q;

  // Synchronizer chains; reset values match the idle pin levels so no false edge.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      csn_sync_q  <= '1;
      clk_sync_q  <= {SS{CLK_IDLE}};
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      resn_sync_q <= '1;
      clk_prev_q  <= CLK_IDLE;
    end else begin
      csn_sync_q  <= SS'({csn_sync_q, spi_csn_i});
      clk_sync_q  <= SS'({clk_sync_q, spi_clk_i});
      mosi_sync_q <= SS'({mosi_sync_q, spi_mosi_i});
      dc_sync_q   <= SS'({dc_sync_q, spi_dc_i});
      resn_sync_q <= SS'({resn_sync_q, spi_resn_i});
      clk_prev_q  <= clk_s;
    end
  end

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    dc_cap_d   = dc_cap_q;
    rx_byte_d  = rx_byte_q;
    rx_dc_d    = rx_dc_q;
    rx_valid_d = done_q;
    if (done_q) begin
      rx_byte_d = shift_q;
      rx_dc_d   = dc_cap_q;
    end
    if (!resn_s) begin
      shift_d    = '0;
      cnt_d      = '0;
      dc_cap_d   = 1'b0;
      rx_byte_d  = '0;
      rx_dc_d    = 1'b0;
      rx_valid_d = 1'b0;
    end else if ((c_use_csn != 0) && csn_s) begin
      // Deselected: any partial byte is dropped by restarting the count.
      cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d = {shift_q[BYTE_W-2:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done_d   = 1'b1;
        dc_cap_d = dc_s;
      end
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dc_cap_q   <= 1'b0;
      rx_byte_q  <= '0;
      rx_dc_q    <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      dc_cap_q   <= dc_cap_d;
      rx_byte_q  <= rx_byte_d;
      rx_dc_q    <= rx_dc_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_byte_o  = rx_byte_q;
  assign rx_dc_o    = rx_dc_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_resn_o = resn_s;

endmodule

// File: rtl/st7789_spi_receiver.sv
// ST7789 display emulator: decodes CASET/RASET/RAMWR from the SPI byte stream
// and emits window-addressed RGB565 pixel writes.
module st7789_spi_receiver
  import st7789_pkg::*;
#(
  parameter int unsigned c_x_size       = 240,
  parameter int unsigned c_y_size       = 240,
  parameter int unsigned c_x_bits       = $clog2(c_x_size),
  parameter int unsigned c_y_bits       = $clog2(c_y_size),
  parameter int unsigned c_clk_polarity = 1,
  parameter int unsigned c_use_csn      = 0,
  parameter int unsigned c_sync_stages  = 2
) (
  input  logic                clk,
  input  logic                resn,
  input  logic                spi_csn,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_dc,
  input  logic                spi_resn,
  output logic [BYTE_W-1:0]   rx_byte,
  output logic                rx_dc,
  output logic                rx_valid,
  output logic [BYTE_W-1:0]   last_cmd,
  output logic [c_x_bits-1:0] pix_x,
  output logic [c_y_bits-1:0] pix_y,
  output logic [COLOR_W-1:0]  pix_color,
  output logic                pix_valid
);

  localparam int unsigned XW = c_x_bits;
  localparam int unsigned YW = c_y_bits;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(c_x_size);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(c_y_size);
  localparam span_t XWIN_RST = '{s: '0, e: COORD_W'(c_x_size - 1)};
  localparam span_t YWIN_RST = '{s: '0, e: COORD_W'(c_y_size - 1)};

  logic              spi_resn_s;
  logic [BYTE_W-1:0] rxb;
  logic              rxdc, rxv;

  spi_byte_rx #(
    .c_clk_polarity(c_clk_polarity),
    .c_use_csn     (c_use_csn),
    .c_sync_stages (c_sync_stages)
  ) u_byte_rx (
    .clk       (clk),
    .resn      (resn),
    .spi_csn_i (spi_csn),
    .spi_clk_i (spi_clk),
    .spi_mosi_i(spi_mosi),
    .spi_dc_i  (spi_dc),
    .spi_resn_i(spi_resn),
    .rx_byte_o (rxb),
    .rx_dc_o   (rxdc),
    .rx_valid_o(rxv),
    .spi_resn_o(spi_resn_s)
  );

  dec_state_t          state_q, state_d;
  logic [BYTE_W-1:0]   last_cmd_q, last_cmd_d;
  logic [23:0]         arg_q, arg_d;
  logic [1:0]          idx_q, idx_d;
  span_t               xwin_q, xwin_d, ywin_q, ywin_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                phase_q, phase_d;
  logic [XW-1:0]       pix_x_q, pix_x_d;
  logic [YW-1:0]       pix_y_q, pix_y_d;
  logic [COLOR_W-1:0]  pix_color_q, pix_color_d;
  logic                pix_valid_q, pix_valid_d;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q     <= IDLE;
      last_cmd_q  <= '0;
      arg_q       <= '0;
      idx_q       <= '0;
      xwin_q      <= XWIN_RST;
      ywin_q      <= YWIN_RST;
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_cmd_q  <= last_cmd_d;
      arg_q       <= arg_d;
      idx_q       <= idx_d;
      xwin_q      <= xwin_d;
      ywin_q      <= ywin_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_cmd_d  = last_cmd_q;
    arg_d       = arg_q;
    idx_d       = idx_q;
    xwin_d      = xwin_q;
    ywin_d      = ywin_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    phase_d     = phase_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_valid_d = 1'b0;

    if (!spi_resn_s) begin
      state_d     = IDLE;
      last_cmd_d  = '0;
      arg_d       = '0;
      idx_d       = '0;
      xwin_d      = XWIN_RST;
      ywin_d      = YWIN_RST;
      x_d         = '0;
      y_d         = '0;
      hi_d        = '0;
      phase_d     = 1'b0;
      pix_x_d     = '0;
      pix_y_d     = '0;
      pix_color_d = '0;
    end else if (rxv && !rxdc) begin
      // A command byte always restarts decoding; pending window args are dropped.
      last_cmd_d = rxb;
      idx_d      = '0;
      case (rxb)
        CMD_CASET: state_d = CASET;
        CMD_RASET: state_d = RASET;
        CMD_RAMWR: begin
          state_d = RAMWR;
          x_d     = xwin_q.s;
          y_d     = ywin_q.s;
          phase_d = 1'b0;
        end
        default:   state_d = SKIP;
      endcase
    end else if (rxv) begin
      case (state_q)
        CASET, RASET: begin
          if (idx_q == 2'd3) begin
            if (state_q == CASET) xwin_d = '{s: arg_q[23:8], e: {arg_q[7:0], rxb}};
            else                  ywin_d = '{s: arg_q[23:8], e: {arg_q[7:0], rxb}};
            state_d = SKIP;
          end else begin
            arg_d = {arg_q[15:0], rxb};
            idx_d = idx_q + 2'd1;
          end
        end
        RAMWR: begin
          if (!phase_q) begin
            hi_d    = rxb;
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            pix_color_d = {hi_q, rxb};
            pix_x_d     = XW'(x_q);
            pix_y_d     = YW'(y_q);
            pix_valid_d = (x_q < X_LIM) && (y_q < Y_LIM);
            // >= rather than == so a degenerate window pins to its start.
            if (x_q >= xwin_q.e) begin
              x_d = xwin_q.s;
              y_d = (y_q >= ywin_q.e) ? ywin_q.s : y_q + 16'd1;
            end else begin
              x_d = x_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_byte   = rxb;
  assign rx_dc     = rxdc;
  assign rx_valid  = rxv;
  assign last_cmd  = last_cmd_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_st7789_spi_receiver.sv
// Directed and randomized bench for st7789_spi_receiver against a
// command-level display model.
module tb_st7789_spi_receiver;

  localparam int XS = 240;
  localparam int YS = 240;

  logic       clk = 1'b0;
  logic       resn = 1'b0;
  logic       spi_csn = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0, spi_dc = 1'b0, spi_resn = 1'b1;
  logic [7:0] rx_byte, last_cmd;
  logic       rx_dc, rx_valid, pix_valid;
  logic [7:0] pix_x, pix_y;
  logic [15:0] pix_color;

  always #5 clk = ~clk;

  st7789_spi_receiver #(
    .c_x_size(XS), .c_y_size(YS), .c_clk_polarity(1), .c_use_csn(1), .c_sync_stages(2)
  ) dut (
    .clk(clk), .resn(resn), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_resn(spi_resn), .rx_byte(rx_byte), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .last_cmd(last_cmd), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .pix_valid(pix_valid)
  );

  typedef struct {int x; int y; int c;} pix_t;
  pix_t obs_q[$];
  pix_t exp_q[$];
  int   rx_count = 0;
  logic [7:0] last_rx = 8'h00;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (pix_valid) obs_q.push_back('{int'(pix_x), int'(pix_y), int'(pix_color)});
    if (rx_valid) begin
      rx_count++;
      last_rx = rx_byte;
    end
  end

  // Command-level model of the display: mode 0 idle, 1 caset, 2 raset, 3 ramwr, 4 skip.
  int m_mode, m_nargs, m_last, m_hi;
  int m_args[3];
  int m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  bit m_have_hi;

  function automatic void model_reset();
    m_mode = 0; m_nargs = 0; m_last = 0; m_hi = 0; m_have_hi = 0;
    m_xs = 0; m_xe = XS - 1; m_ys = 0; m_ye = YS - 1; m_x = 0; m_y = 0;
  endfunction

  function automatic void model_byte(int b, bit dc);
    if (!dc) begin
      m_last = b;
      m_nargs = 0;
      if (b == 'h2A) m_mode = 1;
      else if (b == 'h2B) m_mode = 2;
      else if (b == 'h2C) begin
        m_mode = 3; m_x = m_xs; m_y = m_ys; m_have_hi = 0;
      end else m_mode = 4;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_nargs < 3) begin
        m_args[m_nargs] = b;
        m_nargs++;
      end else begin
        if (m_mode == 1) begin
          m_xs = m_args[0] * 256 + m_args[1]; m_xe = m_args[2] * 256 + b;
        end else begin
          m_ys = m_args[0] * 256 + m_args[1]; m_ye = m_args[2] * 256 + b;
        end
        m_mode = 4;
      end
    end else if (m_mode == 3) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        m_have_hi = 0;
        if (m_x < XS && m_y < YS) exp_q.push_back('{m_x, m_y, m_hi * 256 + b});
        if (m_x >= m_xe) begin
          m_x = m_xs;
          m_y = (m_y >= m_ye) ? m_ys : m_y + 1;
        end else m_x = m_x + 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit dc);
    spi_csn = 1'b0;
    spi_dc  = dc;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); spi_clk = 1'b0; spi_mosi = b[i];
      repeat (2) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    model_byte(int'(b), dc);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_byte(b, 1'b0);
  endtask

  task automatic send_pix(input logic [15:0] c);
    spi_byte(c[15:8], 1'b1);
    spi_byte(c[7:0], 1'b1);
  endtask

  task automatic send_win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send_cmd(cmd);
    send_pix(s);
    send_pix(e);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_pix(input string tag);
    int n;
    settle();
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_x%0d", tag, i), obs_q[i].x, exp_q[i].x);
      chk($sformatf("%s_y%0d", tag, i), obs_q[i].y, exp_q[i].y);
      chk($sformatf("%s_c%0d", tag, i), obs_q[i].c, exp_q[i].c);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int rc0;
    int exp_xy[7][2];
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_rx_dc", rx_dc, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_last_cmd", last_cmd, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_pix_color", pix_color, 0);
    chk("rst_pix_valid", pix_valid, 0);
    resn = 1'b1;
    repeat (4) @(negedge clk);

    // Two pixels in the default window
    send_cmd(8'h2C);
    send_pix(16'hF800);
    send_pix(16'h07E0);
    settle();
    chk("basic_n", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("basic_p0", {obs_q[0].x[7:0], obs_q[0].y[7:0], obs_q[0].c[15:0]}, 32'h0000_F800);
      chk("basic_p1", {obs_q[1].x[7:0], obs_q[1].y[7:0], obs_q[1].c[15:0]}, 32'h0100_07E0);
    end
    chk("basic_last_cmd", last_cmd, 8'h2C);
    check_pix("basic");

    // 3x2 window with wrap back to the top-left corner
    send_win(8'h2A, 16'd0, 16'd2);
    send_win(8'h2B, 16'd5, 16'd6);
    send_cmd(8'h2C);
    for (int i = 0; i < 7; i++) send_pix(16'($urandom));
    settle();
    exp_xy = '{'{0,5}, '{1,5}, '{2,5}, '{0,6}, '{1,6}, '{2,6}, '{0,5}};
    chk("win_n", obs_q.size(), 7);
    for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
      chk($sformatf("win_xy%0d", i), {obs_q[i].x[15:0], obs_q[i].y[15:0]},
          {16'(exp_xy[i][0]), 16'(exp_xy[i][1])});
    end
    check_pix("win");

    // csn rise mid-byte discards the partial byte
    rc0 = rx_count;
    spi_csn = 1'b0;
    spi_dc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); spi_clk = 1'b0; spi_mosi = 1'b1;
      repeat (2) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
    spi_csn = 1'b1;
    repeat (6) @(negedge clk);
    send_cmd(8'h2A);
    settle();
    chk("csn_rx_count", rx_count - rc0, 1);
    chk("csn_rx_byte", last_rx, 8'h2A);
    chk("csn_last_cmd", last_cmd, 8'h2A);
    send_cmd(8'h00);
    spi_csn = 1'b1;
    repeat (4) @(negedge clk);

    // Window straddling the screen edge
    send_win(8'h2A, 16'd239, 16'd240);
    send_win(8'h2B, 16'd0, 16'd239);
    send_cmd(8'h2C);
    send_pix(16'h1234);
    send_pix(16'h5678);
    send_pix(16'h9ABC);
    settle();
    chk("edge_n", obs_q.size(), 2);
    if (obs_q.size() >= 2)
      chk("edge_p1", {obs_q[1].x[15:0], obs_q[1].y[15:0]}, {16'd239, 16'd1});
    check_pix("edge");

    // Soft reset in the middle of a pixel stream
    send_win(8'h2A, 16'd10, 16'd20);
    send_cmd(8'h2C);
    send_pix(16'hAAAA);
    spi_byte(8'h55, 1'b1);
    spi_resn = 1'b0;
    repeat (10) @(negedge clk);
    model_reset();
    chk("sreset_last_cmd", last_cmd, 0);
    chk("sreset_pix_color", pix_color, 0);
    spi_resn = 1'b1;
    repeat (6) @(negedge clk);
    send_pix(16'h1111);
    send_pix(16'h2222);
    check_pix("sreset_ignore");
    send_cmd(8'h2C);
    send_pix(16'hBEEF);
    check_pix("sreset_window");

    // Randomized command mix
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 4))
        0: send_win(8'h2A, 16'($urandom_range(0, 250)), 16'($urandom_range(0, 250)));
        1: send_win(8'h2B, 16'($urandom_range(0, 250)), 16'($urandom_range(0, 250)));
        2: begin
          send_cmd(8'h2C);
          for (int k = $urandom_range(1, 10); k > 0; k--) send_pix(16'($urandom));
        end
        3: begin
          send_cmd(8'h2A);
          spi_byte(8'($urandom), 1'b1);
          spi_byte(8'($urandom), 1'b1);
          send_cmd(8'h2C);
          send_pix(16'($urandom));
          send_pix(16'($urandom));
        end
        default: begin
          send_cmd(8'($urandom_range(16, 40)));
          spi_byte(8'($urandom), 1'b1);
          spi_byte(8'($urandom), 1'b1);
        end
      endcase
      check_pix($sformatf("rand%0d", it));
      chk($sformatf("rand%0d_last_cmd", it), last_cmd, 32'(m_last));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
